// File: rtl/hall_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : hall_pulse_gen_if
// Brief    : Control/config and waveform bundle of the hall pulse generator.
// Revision : 1.0
// ============================================================================
interface hall_pulse_gen_if #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 16
);
  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] period1;
  logic [PERIOD_W-1:0] period2;
  logic [COUNT_W-1:0]  count1;
  logic [COUNT_W-1:0]  count2;
  logic                m1;
  logic                m2;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  pulses1;
  logic [COUNT_W-1:0]  pulses2;

  modport master (
    output start, stop, period1, period2, count1, count2,
    input  m1, m2, busy, done, pulses1, pulses2
  );

  modport slave (
    input  start, stop, period1, period2, count1, count2,
    output m1, m2, busy, done, pulses1, pulses2
  );
endinterface
`default_nettype wire

// File: rtl/hall_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : hall_pulse_gen
// Brief    : Two-channel synthetic hall-sensor square-wave train generator.
// Revision : 1.0
// ============================================================================
module hall_pulse_gen #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  hall_pulse_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [PERIOD_W-1:0] r_per    [2];
  logic [PERIOD_W-1:0] r_ph     [2];
  logic [COUNT_W-1:0]  r_cnt    [2];
  logic [COUNT_W-1:0]  r_pulses [2];
  logic [1:0]          r_m;
  logic [1:0]          r_fin;

  logic [PERIOD_W-1:0] w_per_in    [2];
  logic [PERIOD_W-1:0] w_per_clamp [2];
  logic [PERIOD_W-1:0] w_ph_nxt    [2];
  logic [COUNT_W-1:0]  w_cnt_in    [2];
  logic [1:0]          w_wrap;
  logic [1:0]          w_high;
  logic [1:0]          w_rise;
  logic [1:0]          w_last;
  logic [1:0]          w_fin_nxt;

  assign w_per_in[0] = bus.period1;
  assign w_per_in[1] = bus.period2;
  assign w_cnt_in[0] = bus.count1;
  assign w_cnt_in[1] = bus.count2;

  // Phase counter only ever reaches period-1, so a full-scale period cannot overflow.
  generate
    for (genvar k = 0; k < 2; k++) begin : g_ch
      assign w_per_clamp[k] = (w_per_in[k] < PERIOD_W'(2)) ? PERIOD_W'(2) : w_per_in[k];
      assign w_wrap[k]      = (r_ph[k] == r_per[k] - PERIOD_W'(1));
      assign w_ph_nxt[k]    = w_wrap[k] ? '0 : r_ph[k] + PERIOD_W'(1);
      assign w_high[k]      = (w_ph_nxt[k] >= (r_per[k] >> 1));
      assign w_rise[k]      = (w_ph_nxt[k] == (r_per[k] >> 1));
      assign w_last[k]      = w_wrap[k] && (r_pulses[k] == r_cnt[k]);
      assign w_fin_nxt[k]   = r_fin[k] | w_last[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_m     <= '0;
      r_fin   <= '0;
      for (int k = 0; k < 2; k++) begin
        r_per[k]    <= '0;
        r_ph[k]     <= '0;
        r_cnt[k]    <= '0;
        r_pulses[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start && !bus.stop) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_m     <= '0;
            for (int k = 0; k < 2; k++) begin
              r_per[k]    <= w_per_clamp[k];
              r_cnt[k]    <= w_cnt_in[k];
              r_ph[k]     <= '0;
              r_pulses[k] <= '0;
              r_fin[k]    <= (w_cnt_in[k] == '0);
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_m     <= '0;
          end else begin
            for (int k = 0; k < 2; k++) begin
              if (!r_fin[k]) begin
                r_ph[k] <= w_ph_nxt[k];
                r_m[k]  <= w_high[k] && !w_last[k];
                if (w_rise[k]) r_pulses[k] <= r_pulses[k] + COUNT_W'(1);
                if (w_last[k]) r_fin[k] <= 1'b1;
              end
            end
            if (&w_fin_nxt) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_m     <= '0;
        end
      endcase
    end
  end

  assign bus.m1      = r_m[0];
  assign bus.m2      = r_m[1];
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pulses1 = r_pulses[0];
  assign bus.pulses2 = r_pulses[1];

endmodule
`default_nettype wire

// File: tb/tb_hall_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hall_pulse_gen
// Brief    : Directed self-checking bench for hall_pulse_gen.
// Revision : 1.0
// ============================================================================
module tb_hall_pulse_gen;
  localparam int PW = 16;
  localparam int CW = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hall_pulse_gen_if #(.PERIOD_W(PW), .COUNT_W(CW)) hp_if ();

  hall_pulse_gen #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (hp_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns sampling the cycle right after the accepting edge (cycle 1).
  task automatic kick(input logic [PW-1:0] p1, input logic [CW-1:0] c1,
                      input logic [PW-1:0] p2, input logic [CW-1:0] c2);
    hp_if.period1 = p1;
    hp_if.count1  = c1;
    hp_if.period2 = p2;
    hp_if.count2  = c2;
    hp_if.start   = 1'b1;
    tick();
    hp_if.start   = 1'b0;
  endtask

  task automatic test_reset();
    logic [3+2*CW:0] got;
    resetn = 1'b0;
    tick();
    tick();
    got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done, hp_if.pulses1, hp_if.pulses2};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic(input string tag);
    string em = "00110011001100";
    logic [3:0] got, exp;
    kick(16'd4, 16'd3, 16'd4, 16'd3);
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) tick();
      exp = {em[n-1] == "1", em[n-1] == "1", n <= 13, n == 13};
      got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d m1m2/busy/done got=%b exp=%b", tag, n, got, exp);
      end
    end
    checks++;
    if (hp_if.pulses1 !== 16'd3 || hp_if.pulses2 !== 16'd3) begin
      errors++;
      $display("FAIL %s_pulses got=%0d/%0d exp=3/3", tag, hp_if.pulses1, hp_if.pulses2);
    end
  endtask

  task automatic test_asym();
    string e1 = "001110011100";
    string e2 = "010101010000";
    logic [3:0] got, exp;
    kick(16'd5, 16'd2, 16'd2, 16'd4);
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) tick();
      exp = {e1[n-1] == "1", e2[n-1] == "1", n <= 11, n == 11};
      got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL asym cycle %0d m1m2/busy/done got=%b exp=%b", n, got, exp);
      end
    end
    checks++;
    if (hp_if.pulses1 !== 16'd2 || hp_if.pulses2 !== 16'd4) begin
      errors++;
      $display("FAIL asym_pulses got=%0d/%0d exp=2/4", hp_if.pulses1, hp_if.pulses2);
    end
  endtask

  task automatic test_clamp();
    string em = "010100";
    logic [3:0] got, exp;
    kick(16'd0, 16'd2, 16'd1, 16'd2);
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) tick();
      exp = {em[n-1] == "1", em[n-1] == "1", n <= 5, n == 5};
      got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clamp cycle %0d m1m2/busy/done got=%b exp=%b", n, got, exp);
      end
    end
    checks++;
    if (hp_if.pulses1 !== 16'd2 || hp_if.pulses2 !== 16'd2) begin
      errors++;
      $display("FAIL clamp_pulses got=%0d/%0d exp=2/2", hp_if.pulses1, hp_if.pulses2);
    end
  endtask

  task automatic test_zero_count();
    string e2 = "00011100011100011100011100011100";
    logic [3:0] got, exp;
    kick(16'd3, 16'd0, 16'd6, 16'd5);
    for (int n = 1; n <= 32; n++) begin
      if (n > 1) tick();
      exp = {1'b0, e2[n-1] == "1", n <= 31, n == 31};
      got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL zero_count cycle %0d m1m2/busy/done got=%b exp=%b", n, got, exp);
      end
    end
    checks++;
    if (hp_if.pulses1 !== 16'd0 || hp_if.pulses2 !== 16'd5) begin
      errors++;
      $display("FAIL zero_count_pulses got=%0d/%0d exp=0/5", hp_if.pulses1, hp_if.pulses2);
    end
  endtask

  task automatic test_stop();
    string e1 = "0011001";
    string e2 = "0001110";
    logic [3:0] got, exp;
    kick(16'd4, 16'd10, 16'd6, 16'd10);
    for (int n = 1; n <= 7; n++) begin
      if (n > 1) tick();
      exp = {e1[n-1] == "1", e2[n-1] == "1", 1'b1, 1'b0};
      got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stop_run cycle %0d m1m2/busy/done got=%b exp=%b", n, got, exp);
      end
      // A second start mid-run with different config must be ignored.
      if (n == 4) begin
        hp_if.period1 = 16'd2;
        hp_if.count1  = 16'd1;
        hp_if.period2 = 16'd2;
        hp_if.count2  = 16'd1;
        hp_if.start   = 1'b1;
      end
      if (n == 5) hp_if.start = 1'b0;
    end
    checks++;
    if (hp_if.pulses1 !== 16'd2 || hp_if.pulses2 !== 16'd1) begin
      errors++;
      $display("FAIL stop_prepulses got=%0d/%0d exp=2/1", hp_if.pulses1, hp_if.pulses2);
    end
    hp_if.stop = 1'b1;
    tick();
    hp_if.stop = 1'b0;
    for (int n = 0; n < 6; n++) begin
      got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done};
      checks++;
      if (got !== 4'b0000 || hp_if.pulses1 !== 16'd2 || hp_if.pulses2 !== 16'd1) begin
        errors++;
        $display("FAIL stop_after %0d m1m2/busy/done got=%b exp=0000 pulses got=%0d/%0d exp=2/1",
                 n, got, hp_if.pulses1, hp_if.pulses2);
      end
      tick();
    end
  endtask

  task automatic test_start_stop_collision();
    logic [3:0] got;
    hp_if.period1 = 16'd2;
    hp_if.count1  = 16'd3;
    hp_if.period2 = 16'd2;
    hp_if.count2  = 16'd3;
    hp_if.start   = 1'b1;
    hp_if.stop    = 1'b1;
    tick();
    hp_if.start   = 1'b0;
    hp_if.stop    = 1'b0;
    for (int n = 0; n < 4; n++) begin
      got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL collision cycle %0d m1m2/busy/done got=%b exp=0000", n, got);
      end
      tick();
    end
  endtask

  task automatic test_midrun_reset();
    logic [3+2*CW:0] got;
    kick(16'd4, 16'd3, 16'd4, 16'd3);
    for (int n = 0; n < 4; n++) tick();
    resetn = 1'b0;
    tick();
    got = {hp_if.m1, hp_if.m2, hp_if.busy, hp_if.done, hp_if.pulses1, hp_if.pulses2};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL midrun_reset got=%h exp=0", got);
    end
    resetn = 1'b1;
    tick();
    test_basic("after_reset");
  endtask

  initial begin
    hp_if.start   = 1'b0;
    hp_if.stop    = 1'b0;
    hp_if.period1 = '0;
    hp_if.period2 = '0;
    hp_if.count1  = '0;
    hp_if.count2  = '0;
    test_reset();
    test_basic("basic");
    tick();
    test_asym();
    tick();
    test_clamp();
    tick();
    test_zero_count();
    tick();
    test_stop();
    test_start_stop_collision();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
